// File: rtl/fpu_noncomp_pipe_if.sv
// fpu_noncomp_pipe_if: request/response handshake bundle for the non-computational FP unit
interface fpu_noncomp_pipe_if #(
    parameter int WORD_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        funct5;
    logic [2:0]        rm;
    logic [WORD_W-1:0] rs1;
    logic [WORD_W-1:0] rs2;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_nv;
    logic              out_illegal;
    modport master (
        output in_valid, funct5, rm, rs1, rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_nv, out_illegal
    );
    modport slave (
        input  in_valid, funct5, rm, rs1, rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_nv, out_illegal
    );
endinterface

// File: rtl/fpu_noncomp_pipe.sv
// fpu_noncomp_pipe: pipelined FMIN/FMAX, FEQ/FLT/FLE, FSGNJ* and FCLASS with valid/ready backpressure
module fpu_noncomp_pipe #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int WORD_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input logic               CLK,
    input logic               nRST,
    fpu_noncomp_pipe_if.slave bus
);
    localparam int FLEN = 1 + EXP_W + FRAC_W;
    localparam logic [FLEN-1:0] CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic logic [9:0] f_class(input logic [FLEN-1:0] x);
        logic             s;
        logic [EXP_W-1:0] e;
        logic             emax, emin, mz, q;
        s    = x[FLEN-1];
        e    = x[FLEN-2:FRAC_W];
        emax = &e;
        emin = ~|e;
        mz   = ~|x[FRAC_W-1:0];
        q    = x[FRAC_W-1];
        f_class = {emax & q, emax & ~mz & ~q,
                   ~s & emax & mz, ~s & ~emax & ~emin, ~s & emin & ~mz, ~s & emin & mz,
                   s & emin & mz, s & emin & ~mz, s & ~emax & ~emin, s & emax & mz};
    endfunction

    logic [FLEN-1:0]   w_a, w_b, w_mm;
    logic [9:0]        w_ca, w_cb;
    logic              w_any_nan, w_any_snan, w_zz, w_lt_ord, w_lt, w_eq, w_sgn;
    logic [WORD_W-1:0] w_res;
    logic              w_nv, w_ill, w_in_ready;
    logic [STAGES-1:0] w_adv;

    logic [STAGES-1:0] r_vld;
    logic [WORD_W-1:0] r_res [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];
    logic              r_nv  [STAGES];
    logic              r_ill [STAGES];

    assign w_a        = bus.rs1[FLEN-1:0];
    assign w_b        = bus.rs2[FLEN-1:0];
    assign w_ca       = f_class(w_a);
    assign w_cb       = f_class(w_b);
    assign w_any_nan  = |{w_ca[9:8], w_cb[9:8]};
    assign w_any_snan = w_ca[8] | w_cb[8];
    assign w_zz       = (|w_ca[4:3]) & (|w_cb[4:3]);
    // Total order on non-NaN values with -0 below +0; the zero case is removed for compares
    assign w_lt_ord   = (w_a[FLEN-1] != w_b[FLEN-1]) ? w_a[FLEN-1] :
                        w_a[FLEN-1] ? (w_b[FLEN-2:0] < w_a[FLEN-2:0]) : (w_a[FLEN-2:0] < w_b[FLEN-2:0]);
    assign w_lt       = w_lt_ord & ~w_zz;
    assign w_eq       = (w_a == w_b) | w_zz;
    assign w_mm       = (|w_ca[9:8] & |w_cb[9:8]) ? CANON :
                        (|w_ca[9:8]) ? w_b :
                        (|w_cb[9:8]) ? w_a :
                        (w_lt_ord ^ bus.rm[0]) ? w_a : w_b;
    assign w_sgn      = (bus.rm == 3'b000) ? w_b[FLEN-1] :
                        (bus.rm == 3'b001) ? ~w_b[FLEN-1] : w_a[FLEN-1] ^ w_b[FLEN-1];

    // Decode funct5/rm into result and flags for the request on the bus
    always_comb begin
        w_res = '0;
        w_nv  = 1'b0;
        w_ill = 1'b0;
        case (bus.funct5)
            5'b00101: begin
                w_ill = bus.rm > 3'b001;
                w_res = w_ill ? '0 : WORD_W'($signed(w_mm));
                w_nv  = ~w_ill & w_any_snan;
            end
            5'b10100: begin
                w_ill = bus.rm > 3'b010;
                w_res = w_ill ? '0 :
                        (bus.rm == 3'b010) ? WORD_W'(w_eq & ~w_any_nan) :
                        (bus.rm == 3'b001) ? WORD_W'(w_lt & ~w_any_nan) : WORD_W'((w_lt | w_eq) & ~w_any_nan);
                w_nv  = w_ill ? 1'b0 : (bus.rm == 3'b010) ? w_any_snan : w_any_nan;
            end
            5'b00100: begin
                w_ill = bus.rm > 3'b010;
                w_res = w_ill ? '0 : WORD_W'($signed({w_sgn, w_a[FLEN-2:0]}));
            end
            5'b11100: begin
                w_ill = bus.rm != 3'b001;
                w_res = w_ill ? '0 : WORD_W'(w_ca);
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Ripple the advance condition back from the output: a stage moves when everything after it can
    always_comb begin
        logic w_chain;
        w_chain = bus.out_ready;
        w_adv   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k] = w_chain;
            w_chain  = ~r_vld[k] | w_chain;
        end
        w_in_ready = w_chain;
    end

    // Stage 1 captures the evaluated request; later stages are plain delay registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_res[k] <= '0;
                r_tag[k] <= '0;
                r_nv[k]  <= 1'b0;
                r_ill[k] <= 1'b0;
            end
        end else begin
            if (w_in_ready) begin
                r_vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_res[0] <= w_res;
                    r_tag[0] <= bus.in_tag;
                    r_nv[0]  <= w_nv;
                    r_ill[0] <= w_ill;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (!r_vld[k] || w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_res[k] <= r_res[k-1];
                        r_tag[k] <= r_tag[k-1];
                        r_nv[k]  <= r_nv[k-1];
                        r_ill[k] <= r_ill[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_vld[STAGES-1];
    assign bus.out_result  = r_res[STAGES-1];
    assign bus.out_tag     = r_tag[STAGES-1];
    assign bus.out_nv      = r_nv[STAGES-1];
    assign bus.out_illegal = r_ill[STAGES-1];
endmodule

// File: tb/tb_fpu_noncomp_pipe.sv
// tb_fpu_noncomp_pipe: directed vector table plus backpressure and mid-stream reset sequences
module tb_fpu_noncomp_pipe;
    localparam logic [4:0] MM = 5'b00101, CMP = 5'b10100, SGN = 5'b00100, CLS = 5'b11100;

    typedef struct packed {
        logic        sp;
        logic [4:0]  f;
        logic [2:0]  rm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nv;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vt[$];

    fpu_noncomp_pipe_if #(.WORD_W(32), .TAG_W(5)) h ();
    fpu_noncomp_pipe_if #(.WORD_W(32), .TAG_W(5)) s ();

    fpu_noncomp_pipe #(.EXP_W(5), .FRAC_W(10), .WORD_W(32), .STAGES(3), .TAG_W(5))
        dut_h (.CLK(clk), .nRST(nrst), .bus(h));
    fpu_noncomp_pipe #(.EXP_W(8), .FRAC_W(23), .WORD_W(32), .STAGES(2), .TAG_W(5))
        dut_s (.CLK(clk), .nRST(nrst), .bus(s));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xact(input logic sp, input logic [4:0] f, input logic [2:0] rm,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        output logic [31:0] res, output logic nv, output logic ill,
                        output logic [4:0] tg, output bit to);
        int n;
        @(negedge clk);
        if (sp) begin
            s.in_valid = 1'b1; s.funct5 = f; s.rm = rm; s.rs1 = a; s.rs2 = b; s.in_tag = t;
        end else begin
            h.in_valid = 1'b1; h.funct5 = f; h.rm = rm; h.rs1 = a; h.rs2 = b; h.in_tag = t;
        end
        @(posedge clk);
        @(negedge clk);
        s.in_valid = 1'b0;
        h.in_valid = 1'b0;
        n = 0;
        while (!(sp ? s.out_valid : h.out_valid) && n < 10) begin
            @(negedge clk);
            n++;
        end
        to  = (n >= 10);
        res = sp ? s.out_result : h.out_result;
        nv  = sp ? s.out_nv : h.out_nv;
        ill = sp ? s.out_illegal : h.out_illegal;
        tg  = sp ? s.out_tag : h.out_tag;
    endtask

    initial begin
        logic [31:0] res;
        logic        nv, ill;
        logic [4:0]  tg;
        bit          to;
        h.in_valid = 0; h.funct5 = 0; h.rm = 0; h.rs1 = 0; h.rs2 = 0; h.in_tag = 0; h.out_ready = 1;
        s.in_valid = 0; s.funct5 = 0; s.rm = 0; s.rs1 = 0; s.rs2 = 0; s.in_tag = 0; s.out_ready = 1;

        vt.push_back('{0, MM,  3'd0, 32'h8000, 32'h0000, 32'hFFFF8000, 0, 0});
        vt.push_back('{0, MM,  3'd1, 32'h7E00, 32'h3C00, 32'h00003C00, 0, 0});
        vt.push_back('{0, MM,  3'd1, 32'h7D00, 32'h7E00, 32'h00007E00, 1, 0});
        vt.push_back('{0, MM,  3'd0, 32'h7D00, 32'h3C00, 32'h00003C00, 1, 0});
        vt.push_back('{0, MM,  3'd1, 32'h8000, 32'h0000, 32'h00000000, 0, 0});
        vt.push_back('{0, MM,  3'd0, 32'hC000, 32'h3C00, 32'hFFFFC000, 0, 0});
        vt.push_back('{0, MM,  3'd1, 32'h3C00, 32'h4000, 32'h00004000, 0, 0});
        vt.push_back('{0, CMP, 3'd0, 32'h3C00, 32'h3C00, 32'h1, 0, 0});
        vt.push_back('{0, CMP, 3'd1, 32'hC000, 32'h3C00, 32'h1, 0, 0});
        vt.push_back('{0, CMP, 3'd2, 32'h7E00, 32'h3C00, 32'h0, 0, 0});
        vt.push_back('{0, CMP, 3'd1, 32'h7E00, 32'h3C00, 32'h0, 1, 0});
        vt.push_back('{0, CMP, 3'd2, 32'h8000, 32'h0000, 32'h1, 0, 0});
        vt.push_back('{0, CMP, 3'd1, 32'h8000, 32'h0000, 32'h0, 0, 0});
        vt.push_back('{0, CMP, 3'd0, 32'h4000, 32'h3C00, 32'h0, 0, 0});
        vt.push_back('{0, CMP, 3'd2, 32'h7D00, 32'h7D00, 32'h0, 1, 0});
        vt.push_back('{0, CMP, 3'd1, 32'hC000, 32'hBC00, 32'h1, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h7D00, 32'h0, 32'h100, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h0001, 32'h0, 32'h020, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'hFC00, 32'h0, 32'h001, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h7E00, 32'h0, 32'h200, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h3C00, 32'h0, 32'h040, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h8000, 32'h0, 32'h008, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h0000, 32'h0, 32'h010, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h7C00, 32'h0, 32'h080, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'h8001, 32'h0, 32'h004, 0, 0});
        vt.push_back('{0, CLS, 3'd1, 32'hBC00, 32'h0, 32'h002, 0, 0});
        vt.push_back('{0, SGN, 3'd1, 32'h3C00, 32'h3C00, 32'hFFFFBC00, 0, 0});
        vt.push_back('{0, SGN, 3'd0, 32'hDEAD3C00, 32'h8000, 32'hFFFFBC00, 0, 0});
        vt.push_back('{0, SGN, 3'd2, 32'hBC00, 32'hBC00, 32'h00003C00, 0, 0});
        vt.push_back('{0, CLS, 3'd0, 32'h3C00, 32'h0, 32'h0, 0, 1});
        vt.push_back('{0, SGN, 3'd3, 32'h3C00, 32'h3C00, 32'h0, 0, 1});
        vt.push_back('{0, 5'd0, 3'd0, 32'h7D00, 32'h7D00, 32'h0, 0, 1});
        vt.push_back('{1, SGN, 3'd2, 32'hBF800000, 32'hC0000000, 32'h3F800000, 0, 0});
        vt.push_back('{1, MM,  3'd0, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 0, 0});
        vt.push_back('{1, CLS, 3'd1, 32'h00000001, 32'h0, 32'h020, 0, 0});
        vt.push_back('{1, CMP, 3'd1, 32'h3F800000, 32'h40000000, 32'h1, 0, 0});
        vt.push_back('{1, MM,  3'd1, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1, 0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset h in_ready", 32'(h.in_ready), 32'h1);
        chk("reset h out_valid", 32'(h.out_valid), 32'h0);
        chk("reset h out_result", h.out_result, 32'h0);
        chk("reset h tag/nv/ill", {h.out_tag, h.out_nv, h.out_illegal}, 32'h0);
        chk("reset s in_ready", 32'(s.in_ready), 32'h1);
        chk("reset s out_valid", 32'(s.out_valid), 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            xact(vt[i].sp, vt[i].f, vt[i].rm, vt[i].a, vt[i].b, 5'(i), res, nv, ill, tg, to);
            chk($sformatf("vec%0d timeout", i), 32'(to), 32'h0);
            chk($sformatf("vec%0d result", i), res, vt[i].res);
            chk($sformatf("vec%0d nv", i), 32'(nv), 32'(vt[i].nv));
            chk($sformatf("vec%0d illegal", i), 32'(ill), 32'(vt[i].ill));
            chk($sformatf("vec%0d tag", i), 32'(tg), 32'(i % 32));
        end

        begin
            int          sent, got, c;
            bit          seen_full, prev_stall, in_x, out_x;
            logic [31:0] prev_res;
            logic [4:0]  prev_tag;
            sent = 0; got = 0; seen_full = 0; prev_stall = 0; prev_res = 0; prev_tag = 0;
            for (c = 0; c < 60 && got < 8; c++) begin
                @(negedge clk);
                h.out_ready = !(c >= 4 && c <= 8);
                h.in_valid  = (sent < 8);
                h.funct5 = SGN; h.rm = 3'd0; h.rs2 = 32'h0;
                h.rs1 = 32'h3C00 + 32'(sent);
                h.in_tag = 5'(sent);
                #1;
                in_x  = h.in_valid && h.in_ready;
                out_x = h.out_valid && h.out_ready;
                if (prev_stall && h.out_valid) begin
                    chk($sformatf("stall hold result c%0d", c), h.out_result, prev_res);
                    chk($sformatf("stall hold tag c%0d", c), 32'(h.out_tag), 32'(prev_tag));
                end
                prev_stall = h.out_valid && !h.out_ready;
                prev_res   = h.out_result;
                prev_tag   = h.out_tag;
                if (!h.in_ready && !seen_full) begin
                    seen_full = 1;
                    chk("entries buffered at in_ready drop", 32'(sent - got), 32'd3);
                end
                if (out_x) begin
                    chk($sformatf("bp order tag %0d", got), 32'(h.out_tag), 32'(got));
                    chk($sformatf("bp result %0d", got), h.out_result, 32'h3C00 + 32'(got));
                    got++;
                end
                @(posedge clk);
                if (in_x) sent++;
            end
            chk("bp delivered count", 32'(got), 32'd8);
            chk("bp in_ready dropped", 32'(seen_full), 32'h1);
            @(negedge clk);
            h.in_valid = 0;
            repeat (4) begin
                @(negedge clk);
                chk("bp no duplicate", 32'(h.out_valid), 32'h0);
            end
        end

        begin
            int lat;
            @(negedge clk);
            h.out_ready = 0;
            h.in_valid = 1; h.funct5 = SGN; h.rm = 3'd0; h.rs1 = 32'h3C00; h.rs2 = 32'h0; h.in_tag = 5'd20;
            @(posedge clk);
            @(negedge clk);
            h.in_tag = 5'd21;
            @(posedge clk);
            @(negedge clk);
            h.in_valid = 0;
            nrst = 0;
            @(posedge clk);
            @(negedge clk);
            nrst = 1;
            #1;
            chk("rst mid out_valid", 32'(h.out_valid), 32'h0);
            chk("rst mid in_ready", 32'(h.in_ready), 32'h1);
            chk("rst mid out_tag", 32'(h.out_tag), 32'h0);
            h.out_ready = 1;
            h.in_valid = 1; h.rs1 = 32'h4000; h.in_tag = 5'd9;
            @(posedge clk);
            @(negedge clk);
            h.in_valid = 0;
            lat = 0;
            while (!h.out_valid && lat < 10) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk("rst new latency", 32'(lat), 32'd2);
            chk("rst new tag", 32'(h.out_tag), 32'd9);
            chk("rst new result", h.out_result, 32'h00004000);
            repeat (4) begin
                @(negedge clk);
                chk("rst no stale", 32'(h.out_valid), 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_noncomp_pipe.md
# fpu_noncomp_pipe

Parametrised, pipelined unit for the non-computational floating-point instructions: FMIN/FMAX, FEQ/FLT/FLE, FSGNJ/FSGNJN/FSGNJX and FCLASS. It generalises the half-precision Zhinx operation set to any IEEE-754-style format set by `EXP_W` and `FRAC_W`. Latency and pipeline depth are configurable, and both ends use valid/ready handshakes with full backpressure. It sits beside the FPU arithmetic datapath and takes decoded `funct5`/`rm` fields directly from the instruction.

## Interface
Parameters:
- `EXP_W`, default 5: exponent width.
- `FRAC_W`, default 10: fraction width. `FLEN = 1+EXP_W+FRAC_W`, and `FLEN` must be ≤ `WORD_W`.
- `WORD_W`, default 32: operand and result width, i.e. the integer register width.
- `STAGES`, default 2: pipeline depth. Legal range is 1–4.
- `TAG_W`, default 5: width of the opaque tag, normally `rd`.

Ports:
- `CLK` in, 1: the single clock. All state changes on its rising edge.
- `nRST` in, 1: reset. Synchronous, active-low.
- `in_valid` in, 1: input request valid.
- `in_ready` out, 1: unit can accept a request this cycle.
- `funct5` in, 5: instruction funct5 field.
- `rm` in, 3: instruction rm field, used as the operation sub-select.
- `rs1`, `rs2` in, `WORD_W`: operands. Only bits `[FLEN-1:0]` are used.
- `in_tag` in, `TAG_W`: carried unchanged to `out_tag`.
- `out_valid` out, 1: result valid.
- `out_ready` in, 1: consumer accepts the result.
- `out_result` out, `WORD_W`: result.
- `out_tag` out, `TAG_W`: tag of the result.
- `out_nv` out, 1: invalid-operation exception flag.
- `out_illegal` out, 1: unsupported `funct5`/`rm` combination.

## Operation
- An operand is NaN when its exponent is all ones and its fraction is nonzero.
  - It is an sNaN when the fraction MSB is 0 and a qNaN when the fraction MSB is 1.
- The canonical NaN is sign 0, exponent all ones, fraction `{1, 0...}`. For half precision it is 0x7E00.
- FP results (min/max, sgnj) are sign-extended from bit `FLEN-1` to `WORD_W`.
- Compare results are 0 or 1. The class result is the 10-bit one-hot mask, zero-extended.
- `funct5`=00101 (min/max), `rm` 000 = FMIN, 001 = FMAX:
  - `-0 < +0`.
  - One NaN operand: return the other operand.
  - Both NaN: return the canonical NaN.
  - `nv` = either operand is an sNaN.
- `funct5`=10100 (compare), `rm` 010 = FEQ, 001 = FLT, 000 = FLE:
  - Any NaN operand gives result 0.
  - FEQ: `nv` only on an sNaN operand.
  - FLT/FLE: `nv` on any NaN operand.
  - `+0 == -0`.
- `funct5`=00100 (sign-inject), `rm` 000 = J, 001 = JN, 010 = JX:
  - Result is the magnitude of `rs1` with sign `s2`, `~s2` or `s1^s2` respectively.
  - No flags.
- `funct5`=11100 with `rm`=001 (classify): one-hot mask with the following bits:
  - bit 0: −inf
  - bit 1: −normal
  - bit 2: −subnormal
  - bit 3: −0
  - bit 4: +0
  - bit 5: +subnormal
  - bit 6: +normal
  - bit 7: +inf
  - bit 8: sNaN
  - bit 9: qNaN
- Any other `funct5`/`rm` combination: `out_illegal`=1, `out_result`=0, `out_nv`=0.
- The operation is evaluated combinationally on the accepted inputs and registered into stage 1. Stages 2..`STAGES` are pure delay registers holding valid, result, tag, nv and illegal.

## Timing
- Reset (`nRST` low at a rising edge):
  - All stage valid bits clear.
  - `out_valid`, `out_result`, `out_tag`, `out_nv` and `out_illegal` are 0.
  - `in_ready` is 1 from the first cycle after reset.
- Reset mid-operation discards every in-flight entry. No result from before the reset ever appears.
- Input handshake: a transfer occurs when `in_valid & in_ready` at a rising edge. The inputs must be stable only in that cycle.
- Output handshake: a transfer occurs when `out_valid & out_ready`. While `out_valid=1 & out_ready=0`, every output is held constant.
- Latency: a request accepted at edge N presents `out_valid`=1 after edge N+`STAGES-1`, provided no stall occurs.
- Stage advance rule: stage k advances when stage k+1 is empty or advancing. The last stage advances on `out_ready`.
- `in_ready` = stage 1 empty, or stage 1 advancing. This is a combinational path from `out_ready` through the chain.
- Throughput is one per cycle with `out_ready` held high. The full pipeline holds `STAGES` entries with no loss and no duplication.
- Results always leave in acceptance order.

## Test plan
- **Min/max, half precision.**
  - FMIN(0x8000, 0x0000) → 0xFFFF8000, nv=0.
  - FMAX(0x7E00, 0x3C00) → 0x00003C00, nv=0.
  - FMAX(0x7D00, 0x7E00) → 0x00007E00, nv=1.
- **Compare.**
  - FLE(0x3C00, 0x3C00) → 1.
  - FLT(0xC000, 0x3C00) → 1.
  - FEQ(0x7E00, 0x3C00) → 0, nv=0.
  - FLT(0x7E00, 0x3C00) → 0, nv=1.
- **Classify and sign-inject.**
  - FCLASS of 0x7D00 → 0x100.
  - FCLASS of 0x0001 → 0x020.
  - FCLASS of 0xFC00 → 0x001.
  - FSGNJN(0x3C00, 0x3C00) → 0xFFFFBC00.
  - `funct5`=11100 with `rm`=000 → illegal=1, result 0.
- **Backpressure.**
  - Setup: `STAGES`=3, 8 back-to-back requests, `out_ready` low for cycles 4–8.
  - Required: `in_ready` drops after 3 entries are buffered; all 8 tags come out in order, once each; outputs are stable while stalled.
- **Reset mid-stream.**
  - Setup: `nRST` low for one edge while 2 entries are in flight.
  - Required: next cycle `out_valid`=0 and `in_ready`=1; a new request returns after `STAGES`-1 edges with no stale results.
- **Single precision** (`EXP_W`=8, `FRAC_W`=23).
  - FSGNJX(0xBF800000, 0xC0000000) → 0x3F800000.
  - FMIN(0x7FC00000, 0x7FC00000) → 0x7FC00000.
